onehot_display_decoder: RTL and testbench

//  Inverse of the 8-to-3 priority encoder path: accepts 3-bit position codes over a

---
 rtl/onehot_display_decoder_pkg.sv | 37 +++
 rtl/onehot_display_decoder_disp_fifo2.sv | 51 +++++
 rtl/onehot_display_decoder.sv | 109 ++++++++++
 tb/tb_onehot_display_decoder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/onehot_display_decoder_pkg.sv
// Shared types and constants for the one-hot LED / 7-segment display decoder.
// Segment patterns are {a..g}, active-low, for a common-anode digit.
package onehot_display_decoder_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Indexed by digit: SEG_TABLE[0] is the pattern for '0'.
    localparam logic [7:0][6:0] SEG_TABLE = {
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_e;

    typedef struct packed {
        logic       blank;
        logic [2:0] code;
    } entry_t;

    function automatic logic [7:0] led_of(input entry_t e);
        return e.blank ? 8'h00 : 8'(8'h01 << e.code);
    endfunction

    function automatic logic [6:0] seg_of(input entry_t e);
        return e.blank ? SEG_BLANK : SEG_TABLE[e.code];
    endfunction

endpackage

// File: rtl/onehot_display_decoder_disp_fifo2.sv
// Two-entry FIFO of display entries; caller never pushes when full nor pops when empty.
module disp_fifo2
    import onehot_display_decoder_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  entry_t     wdata,
    output entry_t     rdata,
    output logic       full,
    output logic       empty,
    output logic [1:0] count
);

    entry_t mem [2];
    logic   wr_ptr;
    logic   rd_ptr;

    // Storage carries no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

endmodule

// File: rtl/onehot_display_decoder.sv
// Buffers 3-bit position codes and shows each as a one-hot LED pattern for HOLD_CYCLES clocks.
// Define DISPLAY_DECODER_SEG_EN to also echo the code on an active-low 7-segment digit.
module onehot_display_decoder
    import onehot_display_decoder_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_code,
    input  logic       in_blank,
    output logic [7:0] led,
    output logic [6:0] sseg,
    output logic       busy
);

    localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_e           state;
    state_e           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             push;
    logic             pop;
    entry_t           wr_entry;
    entry_t           fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [1:0]       fifo_count;

    assign in_ready = !rst && !fifo_full;
    assign push     = in_valid && in_ready;
    assign wr_entry = '{blank: in_blank, code: in_code};

    disp_fifo2 u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // A pop always coincides with loading the display registers.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    cnt_next   = CNT_LOAD;
                    state_next = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (cnt != '0) begin
                    cnt_next = cnt - CNT_W'(1);
                end else if (fifo_count != 2'd0) begin
                    pop      = 1'b1;
                    cnt_next = CNT_LOAD;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led <= 8'h00;
        end else if (pop) begin
            led <= led_of(fifo_rdata);
        end
    end

`ifdef DISPLAY_DECODER_SEG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sseg <= SEG_BLANK;
        end else if (pop) begin
            sseg <= seg_of(fifo_rdata);
        end
    end
`else
    assign sseg = SEG_BLANK;
`endif

    assign busy = (state == ST_SHOW);

endmodule

// File: tb/tb_onehot_display_decoder.sv
// Self-checking bench: a cycle model pushes expected display values into a scoreboard
// queue on each accepted transfer and pops them when the display is due to load.
module tb_onehot_display_decoder;

    localparam int unsigned HOLD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_code;
    logic       in_blank;
    logic [7:0] led;
    logic [6:0] sseg;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard entries: {expected led, expected sseg}.
    logic [14:0] sb [$];
    logic [7:0]  m_led;
    logic [6:0]  m_sseg;
    logic        m_show;
    int          m_cnt;
    logic        m_accepted;

    logic [6:0] seg_ref [8] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111};

    onehot_display_decoder #(.HOLD_CYCLES(HOLD)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_code  (in_code),
        .in_blank (in_blank),
        .led      (led),
        .sseg     (sseg),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [14:0] expect_of(input logic blank, input logic [2:0] code);
        logic [7:0] l;
        logic [6:0] s;
        l = blank ? 8'h00 : (8'h01 << code);
`ifdef DISPLAY_DECODER_SEG_EN
        s = blank ? 7'h7F : seg_ref[code];
`else
        s = 7'h7F;
`endif
        return {l, s};
    endfunction

    // Reference model, evaluated on the same edge the DUT samples.
    always @(posedge clk) begin
        logic take;
        logic [14:0] e;
        if (rst) begin
            sb.delete();
            m_led = 8'h00; m_sseg = 7'h7F; m_show = 1'b0; m_cnt = 0;
            m_accepted = 1'b0;
        end else begin
            take = in_valid && (sb.size() != 2);
            if (sb.size() != 0 && (!m_show || m_cnt == 0)) begin
                e = sb.pop_front();
                {m_led, m_sseg} = e;
                m_cnt  = HOLD - 1;
                m_show = 1'b1;
            end else if (m_show && m_cnt != 0) begin
                m_cnt--;
            end else begin
                m_show = 1'b0;
            end
            if (take) sb.push_back(expect_of(in_blank, in_code));
            m_accepted = take;
        end
    end

    // One clock, then compare every output against the model.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check("led", 32'(led), 32'(m_led));
        check("sseg", 32'(sseg), 32'(m_sseg));
        check("busy", 32'(busy), 32'(m_show));
        check("in_ready", 32'(in_ready), 32'(!rst && sb.size() != 2));
    endtask

    task automatic send(input logic blank, input logic [2:0] code);
        int tries;
        in_valid = 1'b1; in_blank = blank; in_code = code;
        tries = 0;
        do begin
            step();
            tries++;
        end while (!m_accepted && tries < 20);
        if (!m_accepted) check("send_timeout", 32'(tries), 32'd0);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_blank = 1'b0; in_code = 3'd3;
        // Reset holds everything off even with a pending offer.
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_led", 32'(led), 32'h00);
            check("rst_sseg", 32'(sseg), 32'h7F);
            check("rst_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        step();

        // Single code: one edge to load, held HOLD cycles, then last value persists.
        send(1'b0, 3'd5);
        step();
        check("code5_led", 32'(led), 32'h20);
        check("code5_busy", 32'(busy), 32'd1);
        idle(HOLD + 2);
        check("code5_persist", 32'(led), 32'h20);
        check("code5_idle", 32'(busy), 32'd0);

        // Back-to-back codes, fourth offer stalls while FIFO is full.
        send(1'b0, 3'd1);
        send(1'b0, 3'd2);
        send(1'b0, 3'd3);
        send(1'b0, 3'd4);
        idle(4 * HOLD + 2);

        // Blank entry: code ignored.
        send(1'b1, 3'd7);
        step();
        check("blank_led", 32'(led), 32'h00);
        check("blank_sseg", 32'(sseg), 32'h7F);
        idle(HOLD + 1);

        // All digits in turn.
        for (int c = 0; c < 8; c++) send(1'b0, 3'(c));
        idle(3 * HOLD + 2);

        // Reset mid-display with two entries buffered.
        send(1'b0, 3'd6);
        send(1'b0, 3'd0);
        send(1'b0, 3'd7);
        step();
        rst = 1'b1;
        step();
        check("flush_led", 32'(led), 32'h00);
        check("flush_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        idle(HOLD + 2);
        check("flush_stale", 32'(led), 32'h00);
        check("flush_sb", 32'(sb.size()), 32'd0);

        // Random traffic.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) != 0) send(1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)));
            else step();
        end
        idle(3 * HOLD + 2);
        check("drain_sb", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
